mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mips_pkg.sv | 32 +++
 rtl/md_divider.sv | 49 ++++
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and constants for the HI/LO multiply-divide unit.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } md_state_t;

  localparam int MD_ITERATIONS = 32;
  localparam int MD_CNT_W      = $clog2(MD_ITERATIONS);

  // Magnitude of v when treated as signed, else v unchanged.
  function automatic logic [31:0] mag32(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_divider.sv
// Restoring divider: unsigned magnitudes in, one quotient bit per step.
module md_divider
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      if (!trial[32]) begin
        rem_q <= trial[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply-divide unit: FSM, sign fix-up and HI/LO registers.
// MULT_DIV_FAST_MULT_EN selects a single-cycle multiplier.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [31:0] hi_q, lo_q, hi_d, lo_d;
  logic        hi_we, lo_we;
  logic        done_q;
  logic        acc_iter;
  logic [31:0] a_q;
  logic        bzero_q, qneg_q, rneg_q;

  md_op_t      op_in;
  logic        is_sgn, is_div;
  logic [31:0] a_mag, b_mag;
  logic [31:0] quo, rem;
  logic        last;

  assign op_in  = md_op_t'(op);
  assign is_sgn = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign is_div = (op_in == OP_DIV) || (op_in == OP_DIVU);
  assign a_mag  = mag32(a, is_sgn);
  assign b_mag  = mag32(b, is_sgn);
  assign last   = (cnt_q == MD_CNT_W'(MD_ITERATIONS - 1));

  md_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (acc_iter && is_div),
    .step      (state_q == S_RUN),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

`ifdef MULT_DIV_FAST_MULT_EN
  logic [63:0] sx, sy, fast_prod;
  assign sx = {{32{a[31] & is_sgn}}, a};
  assign sy = {{32{b[31] & is_sgn}}, b};
  assign fast_prod = sx * sy;
`else
  logic [63:0] prod_q, prod_fix;
  logic [31:0] mcand_q;
  logic [32:0] psum;
  logic        is_mul_q, mneg_q;

  assign psum = {1'b0, prod_q[63:32]}
              + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign prod_fix = mneg_q ? (~prod_q + 64'd1) : prod_q;

  // Shift-add: multiplier sits in the low half and drains out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      is_mul_q <= 1'b0;
      mneg_q   <= 1'b0;
    end else if (acc_iter) begin
      prod_q   <= {32'd0, b_mag};
      mcand_q  <= a_mag;
      is_mul_q <= !is_div;
      mneg_q   <= is_sgn & (a[31] ^ b[31]);
    end else if (state_q == S_RUN) begin
      prod_q   <= {psum, prod_q[31:1]};
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_iter = 1'b0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_in)
            OP_MULT, OP_MULTU: begin
`ifdef MULT_DIV_FAST_MULT_EN
              hi_we = 1'b1;
              lo_we = 1'b1;
              hi_d  = fast_prod[63:32];
              lo_d  = fast_prod[31:0];
`else
              acc_iter = 1'b1;
              state_d  = S_RUN;
`endif
            end
            OP_DIV, OP_DIVU: begin
              acc_iter = 1'b1;
              state_d  = S_RUN;
            end
            OP_MTHI: begin
              hi_we = 1'b1;
              hi_d  = a;
            end
            OP_MTLO: begin
              lo_we = 1'b1;
              lo_d  = a;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (last) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        hi_we   = 1'b1;
        lo_we   = 1'b1;
`ifndef MULT_DIV_FAST_MULT_EN
        if (is_mul_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else
`endif
        if (bzero_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          lo_d = qneg_q ? (~quo + 32'd1) : quo;
          hi_d = rneg_q ? (~rem + 32'd1) : rem;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      a_q     <= '0;
      bzero_q <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hi_we | lo_we;
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
      if (acc_iter) begin
        cnt_q   <= '0;
        a_q     <= a;
        bzero_q <= (b == 32'd0);
        qneg_q  <= is_sgn & (a[31] ^ b[31]);
        rneg_q  <= is_sgn & a[31];
      end else if (state_q == S_RUN) begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors, decoupled monitor.
module tb_mult_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic [31:0] hm = 0, lm = 0;

`ifdef MULT_DIV_FAST_MULT_EN
  localparam int ML = 0;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;

  mult_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        automatic exp_t e = q.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_lat"}, 32'(cyc), 32'(e.due));
        chk({e.name, "_busy"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic wait_idle(string n);
    int i;
    for (i = 0; i < 200; i++) begin
      if (q.size() == 0 && !busy) break;
      @(negedge clk);
    end
    if (i == 200) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=busy required=idle", n);
      q.delete();
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh,
                       input logic [31:0] el, input string n,
                       input int lat);
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    q.push_back('{eh, el, cyc + 1 + lat, n});
    @(negedge clk);
    start = 0; a = 32'h5A5A_A5A5; b = 32'hC3C3_3C3C;
    if (lat > 0) chk({n, "_busy_run"}, {31'd0, busy}, 32'd1);
    wait_idle(n);
    hm = eh; lm = el;
  endtask

  initial begin
    rst_n = 0; start = 0; op = 0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    rst_n = 1;

    do_op(3'd1, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, "multu", ML);
    do_op(3'd0, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult", ML);
    do_op(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,
          "mult_min", ML);
    do_op(3'd2, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div", DL);
    do_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, "divu", DL);
    do_op(3'd2, 32'd100, -32'sd7, 32'd2, 32'hFFFFFFF2, "div_negb", DL);
    do_op(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "divu_zero", DL);
    do_op(3'd2, -32'sd7, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF,
          "div_zero", DL);
    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000,
          "div_ovf", DL);

    // second start mid-divide must be dropped
    @(negedge clk);
    start = 1; op = 3'd3; a = 32'd7; b = 32'd2;
    q.push_back('{32'd1, 32'd3, cyc + 1 + DL, "busy_start"});
    @(negedge clk);
    start = 0;
    repeat (8) @(negedge clk);
    start = 1; op = 3'd4; a = 32'hDEAD;
    @(negedge clk);
    start = 0;
    wait_idle("busy_start");
    hm = 32'd1; lm = 32'd3;

    // no-op opcode
    @(negedge clk);
    start = 1; op = 3'd6; a = 32'h77; b = 32'h1;
    @(negedge clk);
    start = 0;
    chk("nop_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    chk("nop_hi", hi, hm);
    chk("nop_lo", lo, lm);

    // reset during a divide
    do_op(3'd4, 32'h1234, 32'd0, 32'h1234, lm, "mthi", 0);
    @(negedge clk);
    start = 1; op = 3'd2; a = -32'sd7; b = 32'd2;
    @(negedge clk);
    start = 0;
    repeat (13) @(negedge clk);
    rst_n = 0; start = 1; op = 3'd4; a = 32'hBAD;
    @(negedge clk);
    start = 0; rst_n = 1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    @(negedge clk);
    chk("abort_hi2", hi, 0);
    hm = 0; lm = 0;
    do_op(3'd5, 32'd9, 32'd0, 32'd0, 32'd9, "mtlo", 0);

    repeat (40) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
